// File: rtl/synchronous_multichannel_fifo_pkg.sv
// rtl/synchronous_multichannel_fifo_pkg.sv - width helpers shared by the multichannel FIFO controller
// Optional thresholds: SYNCHRONOUS_MULTICHANNEL_FIFO_CONTROLLER_THRESHOLDS_EN (used by the top)
package synchronous_multichannel_fifo_pkg;

   // Per-channel index width; DEPTH need not be a power of two
   function automatic int depth_log2(input int depth);
      return $clog2(depth);
   endfunction

   // Level counts 0..DEPTH inclusive, so one bit wider than the index
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Channels are laid out back to back: address = channel*DEPTH + index
   function automatic int address_width(input int channels, input int depth);
      return $clog2(channels * depth);
   endfunction

endpackage

// File: rtl/fifo_channel_pointers.sv
// rtl/fifo_channel_pointers.sv - one channel's write/read pointer pair with lap bits and level
module fifo_channel_pointers
   import synchronous_multichannel_fifo_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int DEPTH_LOG2 = depth_log2(DEPTH),
   localparam int LEVEL_WIDTH = level_width(DEPTH)
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   flush,
   input  logic                   write_advance,
   input  logic                   read_advance,
   output logic [DEPTH_LOG2-1:0]  wr_index,
   output logic [DEPTH_LOG2-1:0]  rd_index,
   output logic [LEVEL_WIDTH-1:0] level,
   output logic                   empty,
   output logic                   full,
   output logic                   almost_full
);

   localparam logic [DEPTH_LOG2-1:0]  LAST_INDEX   = DEPTH_LOG2'(DEPTH - 1);
   localparam logic [DEPTH_LOG2-1:0]  INDEX_ONE    = DEPTH_LOG2'(1);
   localparam logic [LEVEL_WIDTH-1:0] DEPTH_LEVEL  = LEVEL_WIDTH'(DEPTH);
   localparam logic [LEVEL_WIDTH-1:0] ALMOST_LEVEL = LEVEL_WIDTH'(DEPTH - 1);

   logic [DEPTH_LOG2-1:0] wr_idx_q, wr_idx_d;
   logic [DEPTH_LOG2-1:0] rd_idx_q, rd_idx_d;
   logic                  wr_lap_q, wr_lap_d;
   logic                  rd_lap_q, rd_lap_d;

   always_comb begin
      wr_idx_d = wr_idx_q;
      wr_lap_d = wr_lap_q;
      rd_idx_d = rd_idx_q;
      rd_lap_d = rd_lap_q;
      if (flush) begin
         wr_idx_d = '0;
         wr_lap_d = 1'b0;
         rd_idx_d = '0;
         rd_lap_d = 1'b0;
      end else begin
         if (write_advance) begin
            if (wr_idx_q == LAST_INDEX) begin
               wr_idx_d = '0;
               wr_lap_d = ~wr_lap_q;
            end else begin
               wr_idx_d = wr_idx_q + INDEX_ONE;
            end
         end
         if (read_advance) begin
            if (rd_idx_q == LAST_INDEX) begin
               rd_idx_d = '0;
               rd_lap_d = ~rd_lap_q;
            end else begin
               rd_idx_d = rd_idx_q + INDEX_ONE;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_idx_q <= '0;
         wr_lap_q <= 1'b0;
         rd_idx_q <= '0;
         rd_lap_q <= 1'b0;
      end else begin
         wr_idx_q <= wr_idx_d;
         wr_lap_q <= wr_lap_d;
         rd_idx_q <= rd_idx_d;
         rd_lap_q <= rd_lap_d;
      end
   end

   // Differing laps mean the writer is one full pass ahead of the reader
   assign level       = ((wr_lap_q != rd_lap_q) ? DEPTH_LEVEL : '0)
                      + LEVEL_WIDTH'(wr_idx_q) - LEVEL_WIDTH'(rd_idx_q);
   assign wr_index    = wr_idx_q;
   assign rd_index    = rd_idx_q;
   assign empty       = (level == '0);
   assign full        = (level == DEPTH_LEVEL);
   assign almost_full = (level == ALMOST_LEVEL);

endmodule

// File: rtl/synchronous_multichannel_fifo_controller.sv
// rtl/synchronous_multichannel_fifo_controller.sv - N show-ahead FIFOs sharing one external memory
// Optional thresholds: SYNCHRONOUS_MULTICHANNEL_FIFO_CONTROLLER_THRESHOLDS_EN
module synchronous_multichannel_fifo_controller
   import synchronous_multichannel_fifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int CHANNELS = 4,
   localparam int DEPTH_LOG2    = depth_log2(DEPTH),
   localparam int CHANNELS_LOG2 = $clog2(CHANNELS),
   localparam int ADDRESS_WIDTH = address_width(CHANNELS, DEPTH),
   localparam int LEVEL_WIDTH   = level_width(DEPTH)
) (
   input  logic                            clock,
   input  logic                            resetn,
   input  logic [CHANNELS-1:0]             flush,
   input  logic                            write_enable,
   input  logic [CHANNELS_LOG2-1:0]        write_channel,
   input  logic [WIDTH-1:0]                write_data,
   input  logic                            read_enable,
   input  logic [CHANNELS_LOG2-1:0]        read_channel,
   output logic [WIDTH-1:0]                read_data,
   output logic [CHANNELS-1:0]             empty,
   output logic [CHANNELS-1:0]             full,
   output logic [CHANNELS-1:0]             almost_full,
   output logic                            write_miss,
   output logic                            read_error,
   output logic [CHANNELS*LEVEL_WIDTH-1:0] level,
   output logic                            memory_clock,
   output logic                            memory_write_enable,
   output logic [ADDRESS_WIDTH-1:0]        memory_write_address,
   output logic [WIDTH-1:0]                memory_write_data,
   output logic                            memory_read_enable,
   output logic [ADDRESS_WIDTH-1:0]        memory_read_address,
   input  logic [WIDTH-1:0]                memory_read_data
`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_CONTROLLER_THRESHOLDS_EN
   ,
   input  logic [LEVEL_WIDTH-1:0]          lower_threshold_level,
   input  logic [LEVEL_WIDTH-1:0]          upper_threshold_level,
   output logic [CHANNELS-1:0]             lower_threshold_status,
   output logic [CHANNELS-1:0]             upper_threshold_status
`endif
);

   localparam logic [ADDRESS_WIDTH-1:0] CHANNEL_STRIDE = ADDRESS_WIDTH'(DEPTH);

   logic [DEPTH_LOG2-1:0] wr_index [CHANNELS];
   logic [DEPTH_LOG2-1:0] rd_index [CHANNELS];
   logic [CHANNELS-1:0]   write_advance;
   logic [CHANNELS-1:0]   read_advance;
   logic                  write_perform;
   logic                  read_perform;
   logic                  write_miss_q, write_miss_d;
   logic                  read_error_q, read_error_d;

   // Flush on the addressed channel swallows the access silently (no miss/error)
   always_comb begin
      write_perform = write_enable && !full[write_channel] && !flush[write_channel];
      read_perform  = read_enable && !empty[read_channel] && !flush[read_channel];
      write_miss_d  = write_enable && full[write_channel] && !flush[write_channel];
      read_error_d  = read_enable && empty[read_channel] && !flush[read_channel];
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         write_miss_q <= 1'b0;
         read_error_q <= 1'b0;
      end else begin
         write_miss_q <= write_miss_d;
         read_error_q <= read_error_d;
      end
   end

   genvar c;
   generate
      for (c = 0; c < CHANNELS; c++) begin : g_channel
         assign write_advance[c] = write_perform && (write_channel == CHANNELS_LOG2'(c));
         assign read_advance[c]  = read_perform && (read_channel == CHANNELS_LOG2'(c));

         fifo_channel_pointers #(
            .DEPTH (DEPTH)
         ) u_pointers (
            .clock         (clock),
            .resetn        (resetn),
            .flush         (flush[c]),
            .write_advance (write_advance[c]),
            .read_advance  (read_advance[c]),
            .wr_index      (wr_index[c]),
            .rd_index      (rd_index[c]),
            .level         (level[c*LEVEL_WIDTH +: LEVEL_WIDTH]),
            .empty         (empty[c]),
            .full          (full[c]),
            .almost_full   (almost_full[c])
         );

`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_CONTROLLER_THRESHOLDS_EN
         assign lower_threshold_status[c] = (level[c*LEVEL_WIDTH +: LEVEL_WIDTH] <= lower_threshold_level);
         assign upper_threshold_status[c] = (level[c*LEVEL_WIDTH +: LEVEL_WIDTH] >= upper_threshold_level);
`endif
      end
   endgenerate

   // Write strobe is held low while reset is asserted even if write_enable is high
   assign memory_clock         = clock;
   assign memory_write_enable  = write_perform && resetn;
   assign memory_write_address = ADDRESS_WIDTH'(write_channel) * CHANNEL_STRIDE
                               + ADDRESS_WIDTH'(wr_index[write_channel]);
   assign memory_write_data    = write_data;

   // Show-ahead: the head of the selected channel is always presented
   assign memory_read_enable   = !empty[read_channel];
   assign memory_read_address  = ADDRESS_WIDTH'(read_channel) * CHANNEL_STRIDE
                               + ADDRESS_WIDTH'(rd_index[read_channel]);
   assign read_data            = memory_read_data;

   assign write_miss           = write_miss_q;
   assign read_error           = read_error_q;

endmodule

// File: tb/tb_synchronous_multichannel_fifo_controller.sv
// tb/tb_synchronous_multichannel_fifo_controller.sv - directed vector bench for the multichannel FIFO controller
module tb_synchronous_multichannel_fifo_controller;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        resetn;
   int          total = 0;
   int          bad   = 0;

   // DUT a: DEPTH=4, CHANNELS=4
   logic [3:0]  flush;
   logic        write_enable, read_enable;
   logic [1:0]  write_channel, read_channel;
   logic [7:0]  write_data, read_data;
   logic [3:0]  empty, full, almost_full;
   logic        write_miss, read_error;
   logic [11:0] level;
   logic        mclk, mwe, mre;
   logic [3:0]  mwa, mra;
   logic [7:0]  mwd, mrd;
   logic [7:0]  mem_a [16];

   // DUT b: DEPTH=3, CHANNELS=4
   logic        b_we, b_re;
   logic [7:0]  b_wd, b_rd;
   logic [3:0]  b_empty, b_full, b_af;
   logic        b_wm, b_rerr;
   logic [11:0] b_level;
   logic        b_mclk, b_mwe, b_mre;
   logic [3:0]  b_mwa, b_mra;
   logic [7:0]  b_mwd, b_mrd;
   logic [7:0]  mem_b [16];

`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_CONTROLLER_THRESHOLDS_EN
   logic [2:0]  lower_thr, upper_thr;
   logic [3:0]  lts, uts, b_lts, b_uts;
`endif

   always @(posedge mclk) if (mwe) mem_a[mwa] <= mwd;
   assign mrd = mem_a[mra];
   always @(posedge b_mclk) if (b_mwe) mem_b[b_mwa] <= b_mwd;
   assign b_mrd = mem_b[b_mra];

   synchronous_multichannel_fifo_controller #(.WIDTH(8), .DEPTH(4), .CHANNELS(4)) u_dut_a (
      .clock(clock), .resetn(resetn), .flush(flush),
      .write_enable(write_enable), .write_channel(write_channel), .write_data(write_data),
      .read_enable(read_enable), .read_channel(read_channel), .read_data(read_data),
      .empty(empty), .full(full), .almost_full(almost_full),
      .write_miss(write_miss), .read_error(read_error), .level(level),
      .memory_clock(mclk), .memory_write_enable(mwe), .memory_write_address(mwa),
      .memory_write_data(mwd), .memory_read_enable(mre), .memory_read_address(mra),
      .memory_read_data(mrd)
`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_CONTROLLER_THRESHOLDS_EN
      , .lower_threshold_level(lower_thr), .upper_threshold_level(upper_thr),
      .lower_threshold_status(lts), .upper_threshold_status(uts)
`endif
   );

   synchronous_multichannel_fifo_controller #(.WIDTH(8), .DEPTH(3), .CHANNELS(4)) u_dut_b (
      .clock(clock), .resetn(resetn), .flush(4'b0000),
      .write_enable(b_we), .write_channel(2'd1), .write_data(b_wd),
      .read_enable(b_re), .read_channel(2'd1), .read_data(b_rd),
      .empty(b_empty), .full(b_full), .almost_full(b_af),
      .write_miss(b_wm), .read_error(b_rerr), .level(b_level),
      .memory_clock(b_mclk), .memory_write_enable(b_mwe), .memory_write_address(b_mwa),
      .memory_write_data(b_mwd), .memory_read_enable(b_mre), .memory_read_address(b_mra),
      .memory_read_data(b_mrd)
`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_CONTROLLER_THRESHOLDS_EN
      , .lower_threshold_level(lower_thr), .upper_threshold_level(upper_thr),
      .lower_threshold_status(b_lts), .upper_threshold_status(b_uts)
`endif
   );

   typedef struct {
      logic        we;
      logic [1:0]  wc;
      logic [7:0]  wd;
      logic        re;
      logic [1:0]  rc;
      logic [3:0]  fl;
      logic        mwe;
      logic [11:0] lvl;
      logic        wm;
      logic        rerr;
      logic        chk;
      logic [7:0]  rd;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [11:0] lv(input int a, input int b, input int c, input int d);
      return {3'(d), 3'(c), 3'(b), 3'(a)};
   endfunction

   function automatic vec_t mk(input logic we, input logic [1:0] wc, input logic [7:0] wd,
                               input logic re, input logic [1:0] rc, input logic [3:0] fl,
                               input logic exp_mwe, input logic [11:0] lvl, input logic wm,
                               input logic rerr, input logic chk, input logic [7:0] rd);
      vec_t v;
      v.we = we; v.wc = wc; v.wd = wd; v.re = re; v.rc = rc; v.fl = fl;
      v.mwe = exp_mwe; v.lvl = lvl; v.wm = wm; v.rerr = rerr; v.chk = chk; v.rd = rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      flush = 4'b0000; write_enable = 1'b0; write_channel = 2'd0; write_data = 8'h00;
      read_enable = 1'b0; read_channel = 2'd0; b_we = 1'b0; b_re = 1'b0; b_wd = 8'h00;
   endtask

   initial begin
      logic [3:0] exp_e, exp_f, exp_af;
      logic [2:0] l;
      vec_t v;

      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_CONTROLLER_THRESHOLDS_EN
      lower_thr = 3'd1;
      upper_thr = 3'd3;
`endif
      idle_inputs();
      resetn = 1'b0;
      write_enable = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("reset mwe", 32'(mwe), 32'(1'b0));
      chk("reset empty", 32'(empty), 32'hF);
      chk("reset full", 32'(full), 32'h0);
      chk("reset almost_full", 32'(almost_full), 32'h0);
      chk("reset level", 32'(level), 32'h0);
      chk("reset write_miss", 32'(write_miss), 32'h0);
      chk("reset read_error", 32'(read_error), 32'h0);
      @(negedge clock);
      idle_inputs();
      resetn = 1'b1;

      vecs.push_back(mk(1, 2, 8'h11, 0, 2, 4'b0000, 1, lv(0, 0, 1, 0), 0, 0, 1, 8'h11));
      vecs.push_back(mk(1, 2, 8'h12, 0, 2, 4'b0000, 1, lv(0, 0, 2, 0), 0, 0, 1, 8'h11));
      vecs.push_back(mk(1, 2, 8'h13, 0, 2, 4'b0000, 1, lv(0, 0, 3, 0), 0, 0, 1, 8'h11));
      vecs.push_back(mk(1, 2, 8'h14, 0, 2, 4'b0000, 1, lv(0, 0, 4, 0), 0, 0, 1, 8'h11));
      vecs.push_back(mk(1, 2, 8'h15, 0, 2, 4'b0000, 0, lv(0, 0, 4, 0), 1, 0, 1, 8'h11));
      vecs.push_back(mk(0, 0, 8'h00, 0, 2, 4'b0000, 0, lv(0, 0, 4, 0), 0, 0, 1, 8'h11));
      vecs.push_back(mk(0, 0, 8'h00, 1, 2, 4'b0000, 0, lv(0, 0, 3, 0), 0, 0, 1, 8'h12));
      vecs.push_back(mk(1, 2, 8'h16, 1, 2, 4'b0000, 1, lv(0, 0, 3, 0), 0, 0, 1, 8'h13));
      vecs.push_back(mk(0, 0, 8'h00, 1, 3, 4'b0000, 0, lv(0, 0, 3, 0), 0, 1, 0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 0, 2, 4'b0000, 0, lv(0, 0, 3, 0), 0, 0, 1, 8'h13));
      vecs.push_back(mk(1, 0, 8'hA0, 0, 0, 4'b0000, 1, lv(1, 0, 3, 0), 0, 0, 1, 8'hA0));
      vecs.push_back(mk(1, 0, 8'hA1, 0, 0, 4'b0000, 1, lv(2, 0, 3, 0), 0, 0, 1, 8'hA0));
      vecs.push_back(mk(1, 0, 8'hA2, 0, 0, 4'b0000, 1, lv(3, 0, 3, 0), 0, 0, 1, 8'hA0));
      vecs.push_back(mk(1, 0, 8'hA3, 0, 0, 4'b0000, 1, lv(4, 0, 3, 0), 0, 0, 1, 8'hA0));
      vecs.push_back(mk(1, 0, 8'hA4, 1, 0, 4'b0000, 0, lv(3, 0, 3, 0), 1, 0, 1, 8'hA1));
      vecs.push_back(mk(1, 3, 8'h33, 1, 3, 4'b0000, 1, lv(3, 0, 3, 1), 0, 1, 1, 8'h33));
      vecs.push_back(mk(1, 1, 8'hB0, 0, 1, 4'b0000, 1, lv(3, 1, 3, 1), 0, 0, 1, 8'hB0));
      vecs.push_back(mk(1, 1, 8'hB1, 0, 1, 4'b0000, 1, lv(3, 2, 3, 1), 0, 0, 1, 8'hB0));
      vecs.push_back(mk(1, 1, 8'hB2, 1, 1, 4'b0010, 0, lv(3, 0, 3, 1), 0, 0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 1, 2, 4'b0000, 0, lv(3, 0, 2, 1), 0, 0, 1, 8'h14));
      vecs.push_back(mk(0, 0, 8'h00, 1, 2, 4'b0000, 0, lv(3, 0, 1, 1), 0, 0, 1, 8'h16));
      vecs.push_back(mk(0, 0, 8'h00, 1, 2, 4'b0000, 0, lv(3, 0, 0, 1), 0, 0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 1, 2, 4'b0000, 0, lv(3, 0, 0, 1), 0, 1, 0, 8'h00));
      vecs.push_back(mk(1, 1, 8'hC0, 0, 1, 4'b0000, 1, lv(3, 1, 0, 1), 0, 0, 1, 8'hC0));
      vecs.push_back(mk(1, 0, 8'hD0, 1, 0, 4'b0001, 0, lv(0, 1, 0, 1), 0, 0, 0, 8'h00));
      vecs.push_back(mk(1, 1, 8'hD1, 0, 1, 4'b1000, 1, lv(0, 2, 0, 0), 0, 0, 1, 8'hC0));

      foreach (vecs[i]) begin
         v = vecs[i];
         @(negedge clock);
         write_enable = v.we; write_channel = v.wc; write_data = v.wd;
         read_enable = v.re; read_channel = v.rc; flush = v.fl;
         #1;
         chk($sformatf("v%0d mem_we", i), 32'(mwe), 32'(v.mwe));
         @(posedge clock);
         #1;
         for (int c = 0; c < 4; c++) begin
            l = v.lvl[c*3 +: 3];
            exp_e[c]  = (l == 3'd0);
            exp_f[c]  = (l == 3'd4);
            exp_af[c] = (l == 3'd3);
         end
         chk($sformatf("v%0d level", i), 32'(level), 32'(v.lvl));
         chk($sformatf("v%0d empty", i), 32'(empty), 32'(exp_e));
         chk($sformatf("v%0d full", i), 32'(full), 32'(exp_f));
         chk($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(exp_af));
         chk($sformatf("v%0d write_miss", i), 32'(write_miss), 32'(v.wm));
         chk($sformatf("v%0d read_error", i), 32'(read_error), 32'(v.rerr));
         if (v.chk) chk($sformatf("v%0d read_data", i), 32'(read_data), 32'(v.rd));
      end
      @(negedge clock);
      idle_inputs();

      for (int k = 0; k < 7; k++) begin
         @(negedge clock);
         b_we = 1'b1; b_re = 1'b0; b_wd = 8'(8'h40 + k);
         #1;
         chk($sformatf("d3 pair%0d waddr", k), 32'(b_mwa), 32'(3 + (k % 3)));
         @(posedge clock);
         #1;
         chk($sformatf("d3 pair%0d level_w", k), 32'(b_level[5:3]), 32'd1);
         chk($sformatf("d3 pair%0d data", k), 32'(b_rd), 32'(8'h40 + k));
         chk($sformatf("d3 pair%0d raddr_range", k), 32'(b_mra >= 4'd3 && b_mra <= 4'd5), 32'd1);
         @(negedge clock);
         b_we = 1'b0; b_re = 1'b1;
         @(posedge clock);
         #1;
         chk($sformatf("d3 pair%0d level_r", k), 32'(b_level[5:3]), 32'd0);
         chk($sformatf("d3 pair%0d rerr", k), 32'(b_rerr), 32'd0);
      end
      @(negedge clock);
      idle_inputs();

      // Mid-operation reset: channel 1 still holds two entries
      #2 resetn = 1'b0;
      #1;
      chk("midreset level", 32'(level), 32'h0);
      chk("midreset empty", 32'(empty), 32'hF);
      chk("midreset full", 32'(full), 32'h0);
      @(negedge clock);
      resetn = 1'b1;

`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_CONTROLLER_THRESHOLDS_EN
      for (int s = 0; s < 4; s++) begin
         if (s > 0) begin
            @(negedge clock);
            write_enable = 1'b1; write_channel = 2'd0; write_data = 8'(8'h60 + s);
            @(posedge clock);
            #1;
         end
         chk($sformatf("thr lvl%0d lower", s), 32'(lts[0]), 32'(s <= 1));
         chk($sformatf("thr lvl%0d upper", s), 32'(uts[0]), 32'(s >= 3));
      end
      @(negedge clock);
      idle_inputs();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
